// File: rtl/execute_operand_stage_if.sv
// Decode-to-execute bundle for the ID/EX register: decode control/data and forwarding
// sources in, registered EX control and ALU operands out.
interface execute_operand_stage_if;
  logic        FlushE;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, SignImmD;
  logic [4:0]  RsD, RtD, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUOutM, ResultW;

  logic        RegWriteE, MemtoRegE, MemWriteE, ValidE;
  logic [2:0]  ALUControlE;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic [4:0]  WriteRegE, RsE, RtE;

  modport master (
    output FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
           RD1D, RD2D, SignImmD, RsD, RtD, RdD, ForwardAE, ForwardBE, ALUOutM, ResultW,
    input  RegWriteE, MemtoRegE, MemWriteE, ValidE, ALUControlE, SrcAE, SrcBE,
           WriteDataE, WriteRegE, RsE, RtE
  );

  modport slave (
    input  FlushE, RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
           RD1D, RD2D, SignImmD, RsD, RtD, RdD, ForwardAE, ForwardBE, ALUOutM, ResultW,
    output RegWriteE, MemtoRegE, MemWriteE, ValidE, ALUControlE, SrcAE, SrcBE,
           WriteDataE, WriteRegE, RsE, RtE
  );
endinterface

// File: rtl/execute_operand_stage.sv
// ID/EX pipeline register with bubble insertion, plus EX-stage forwarding muxes,
// ALU source-B select and destination-register select.
module execute_operand_stage (
  input  logic                          clk,
  input  logic                          reset,
  execute_operand_stage_if.slave        io_bus
);
  typedef struct packed {
    logic        reg_write;
    logic        memto_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
  } idex_t;

  idex_t       r_ex, w_nxt;
  logic [31:0] w_src_a, w_wdata;

  // A flushed slot is an all-zero bubble, identical to the reset image.
  always_comb begin
    w_nxt = '0;
    if (!io_bus.FlushE) begin
      w_nxt.reg_write = io_bus.RegWriteD;
      w_nxt.memto_reg = io_bus.MemtoRegD;
      w_nxt.mem_write = io_bus.MemWriteD;
      w_nxt.alu_src   = io_bus.ALUSrcD;
      w_nxt.reg_dst   = io_bus.RegDstD;
      w_nxt.alu_ctrl  = io_bus.ALUControlD;
      w_nxt.rd1       = io_bus.RD1D;
      w_nxt.rd2       = io_bus.RD2D;
      w_nxt.imm       = io_bus.SignImmD;
      w_nxt.rs        = io_bus.RsD;
      w_nxt.rt        = io_bus.RtD;
      w_nxt.rd        = io_bus.RdD;
      w_nxt.valid     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_ex <= '0;
    else       r_ex <= w_nxt;
  end

  // Select 11 is reserved and falls back to the register-file value.
  always_comb begin
    w_src_a = r_ex.rd1;
    case (io_bus.ForwardAE)
      2'b01:   w_src_a = io_bus.ResultW;
      2'b10:   w_src_a = io_bus.ALUOutM;
      default: w_src_a = r_ex.rd1;
    endcase
  end

  always_comb begin
    w_wdata = r_ex.rd2;
    case (io_bus.ForwardBE)
      2'b01:   w_wdata = io_bus.ResultW;
      2'b10:   w_wdata = io_bus.ALUOutM;
      default: w_wdata = r_ex.rd2;
    endcase
  end

  assign io_bus.RegWriteE   = r_ex.reg_write;
  assign io_bus.MemtoRegE   = r_ex.memto_reg;
  assign io_bus.MemWriteE   = r_ex.mem_write;
  assign io_bus.ValidE      = r_ex.valid;
  assign io_bus.ALUControlE = r_ex.alu_ctrl;
  assign io_bus.SrcAE       = w_src_a;
  assign io_bus.WriteDataE  = w_wdata;
  assign io_bus.SrcBE       = r_ex.alu_src ? r_ex.imm : w_wdata;
  assign io_bus.WriteRegE   = r_ex.reg_dst ? r_ex.rd : r_ex.rt;
  assign io_bus.RsE         = r_ex.rs;
  assign io_bus.RtE         = r_ex.rt;
endmodule

// File: tb/tb_execute_operand_stage.sv
// Scoreboard bench for execute_operand_stage: expected EX contents are queued per edge
// and compared (with the spec's forwarding/select rules) once the edge has passed.
module tb_execute_operand_stage;
  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  execute_operand_stage_if bus ();
  execute_operand_stage dut (.clk(clk), .reset(reset), .io_bus(bus));

  typedef struct packed {
    logic        rw, m2r, mw, vld, alusrc, regdst;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } ex_t;

  ex_t sbq[$];
  int  n_cmp = 0;
  int  n_err = 0;

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r);
    case (s)
      2'b01:   return bus.ResultW;
      2'b10:   return bus.ALUOutM;
      default: return r;
    endcase
  endfunction

  function automatic logic [117:0] exp_vec(input ex_t e);
    logic [31:0] wd;
    wd = fwd(bus.ForwardBE, e.rd2);
    return {e.rw, e.m2r, e.mw, e.vld, e.alu, fwd(bus.ForwardAE, e.rd1),
            (e.alusrc ? e.imm : wd), wd, (e.regdst ? e.rd : e.rt), e.rs, e.rt};
  endfunction

  function automatic logic [117:0] dut_vec();
    return {bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ValidE, bus.ALUControlE,
            bus.SrcAE, bus.SrcBE, bus.WriteDataE, bus.WriteRegE, bus.RsE, bus.RtE};
  endfunction

  function automatic ex_t mk(input logic rw, m2r, mw, alusrc, regdst, input logic [2:0] alu,
                             input logic [31:0] rd1, rd2, imm, input logic [4:0] rs, rt, rd);
    ex_t e;
    e = '0;
    e.rw = rw; e.m2r = m2r; e.mw = mw; e.alusrc = alusrc; e.regdst = regdst; e.alu = alu;
    e.rd1 = rd1; e.rd2 = rd2; e.imm = imm; e.rs = rs; e.rt = rt; e.rd = rd;
    return e;
  endfunction

  // Drive one decode slot, queue what EX must hold after the edge, then step past it.
  task automatic issue(input ex_t d, input logic flush, input logic rst);
    ex_t x;
    bus.RegWriteD = d.rw;  bus.MemtoRegD = d.m2r; bus.MemWriteD = d.mw;
    bus.ALUSrcD = d.alusrc; bus.RegDstD = d.regdst; bus.ALUControlD = d.alu;
    bus.RD1D = d.rd1; bus.RD2D = d.rd2; bus.SignImmD = d.imm;
    bus.RsD = d.rs; bus.RtD = d.rt; bus.RdD = d.rd;
    bus.FlushE = flush;
    reset = rst;
    x = d;
    x.vld = 1'b1;
    if (rst || flush) x = '0;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic [1:0] a, b, input logic [31:0] alu_m, res_w);
    bus.ForwardAE = a; bus.ForwardBE = b; bus.ALUOutM = alu_m; bus.ResultW = res_w;
  endtask

  task automatic test_reset();
    ex_t e;
    set_fwd(2'b00, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      issue(mk(1,1,1,1,1,3'b111,32'hDEAD,32'hBEEF,32'h1234,5'd1,5'd2,5'd3), 1'b0, 1'b1);
      e = sbq.pop_front();
      n_cmp++;
      if (dut_vec() !== exp_vec(e) || dut_vec() !== 118'd0) begin
        n_err++;
        $display("FAIL reset[%0d] got %h want %h", i, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_load();
    ex_t e;
    set_fwd(2'b00, 2'b00, 32'h0, 32'h0);
    issue(mk(1,0,0,0,0,3'b010,32'h5,32'h3,32'h0,5'd0,5'd0,5'd0), 1'b0, 1'b0);
    e = sbq.pop_front();
    n_cmp++;
    if (dut_vec() !== exp_vec(e)) begin
      n_err++;
      $display("FAIL load got %h want %h", dut_vec(), exp_vec(e));
    end
    n_cmp++;
    if ({bus.SrcAE, bus.SrcBE, bus.ALUControlE, bus.RegWriteE, bus.ValidE} !==
        {32'd5, 32'd3, 3'b010, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL load_fields got A=%h B=%h alu=%b rw=%b v=%b", bus.SrcAE, bus.SrcBE,
               bus.ALUControlE, bus.RegWriteE, bus.ValidE);
    end
  endtask

  task automatic test_imm_dst();
    ex_t e;
    for (int rd_sel = 0; rd_sel < 2; rd_sel++) begin
      issue(mk(1,0,0,1,rd_sel[0],3'b010,32'h7,32'h11,32'hFFFFFFFC,5'd2,5'd9,5'd4), 1'b0, 1'b0);
      e = sbq.pop_front();
      n_cmp++;
      if (dut_vec() !== exp_vec(e)) begin
        n_err++;
        $display("FAIL imm_dst[%0d] got %h want %h", rd_sel, dut_vec(), exp_vec(e));
      end
      n_cmp++;
      if ({bus.SrcBE, bus.WriteDataE, bus.WriteRegE} !==
          {32'hFFFFFFFC, 32'h11, (rd_sel == 1) ? 5'd4 : 5'd9}) begin
        n_err++;
        $display("FAIL imm_dst_fields[%0d] got B=%h wd=%h wr=%0d", rd_sel, bus.SrcBE,
                 bus.WriteDataE, bus.WriteRegE);
      end
    end
  endtask

  // Sweep all select pairs combinationally while one instruction sits in EX.
  task automatic test_forward();
    ex_t e;
    logic [31:0] want_a, want_b;
    set_fwd(2'b00, 2'b00, 32'h0, 32'h0);
    issue(mk(0,0,0,0,0,3'b000,32'h1,32'h1,32'h55,5'd3,5'd4,5'd5), 1'b0, 1'b0);
    e = sbq.pop_front();
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        set_fwd(a[1:0], b[1:0], 32'hAAAA0000, 32'h0000BBBB);
        #2;
        want_a = (a == 2) ? 32'hAAAA0000 : (a == 1) ? 32'h0000BBBB : 32'h1;
        want_b = (b == 2) ? 32'hAAAA0000 : (b == 1) ? 32'h0000BBBB : 32'h1;
        n_cmp++;
        if (dut_vec() !== exp_vec(e) ||
            {bus.SrcAE, bus.SrcBE, bus.WriteDataE} !== {want_a, want_b, want_b}) begin
          n_err++;
          $display("FAIL fwd a=%0d b=%0d got A=%h B=%h wd=%h want A=%h B=%h", a, b,
                   bus.SrcAE, bus.SrcBE, bus.WriteDataE, want_a, want_b);
        end
      end
    end
    set_fwd(2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic test_flush();
    ex_t e;
    issue(mk(1,0,1,1,0,3'b010,32'h10,32'h20,32'h8,5'd6,5'd7,5'd8), 1'b1, 1'b0);
    e = sbq.pop_front();
    n_cmp++;
    if (dut_vec() !== exp_vec(e) ||
        {bus.MemWriteE, bus.RegWriteE, bus.ValidE, bus.ALUControlE} !== 6'b0) begin
      n_err++;
      $display("FAIL flush_store got %h want %h", dut_vec(), exp_vec(e));
    end
    for (int i = 0; i < 2; i++) begin
      issue(mk(1,1,0,0,1,3'b110,32'h3,32'h4,32'h5,5'd9,5'd10,5'd11), 1'b1, 1'b0);
      e = sbq.pop_front();
      n_cmp++;
      if (dut_vec() !== exp_vec(e) || bus.ValidE !== 1'b0) begin
        n_err++;
        $display("FAIL flush_b2b[%0d] got %h want %h", i, dut_vec(), exp_vec(e));
      end
    end
  endtask

  task automatic test_reset_prio();
    ex_t e;
    issue(mk(1,1,1,0,0,3'b011,32'h9,32'h9,32'h9,5'd1,5'd1,5'd1), 1'b1, 1'b1);
    e = sbq.pop_front();
    n_cmp++;
    if (dut_vec() !== exp_vec(e)) begin
      n_err++;
      $display("FAIL flush_and_reset got %h want %h", dut_vec(), exp_vec(e));
    end
    issue(mk(1,0,0,0,1,3'b010,32'hA,32'hB,32'hC,5'd12,5'd13,5'd14), 1'b0, 1'b0);
    e = sbq.pop_front();
    n_cmp++;
    if (dut_vec() !== exp_vec(e) || bus.ValidE !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_load got %h want %h", dut_vec(), exp_vec(e));
    end
    issue(mk(1,0,0,0,1,3'b001,32'h1A,32'h1B,32'h1C,5'd15,5'd16,5'd17), 1'b0, 1'b1);
    e = sbq.pop_front();
    n_cmp++;
    if (dut_vec() !== exp_vec(e) || bus.ValidE !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_reset got %h want %h", dut_vec(), exp_vec(e));
    end
    issue(mk(0,1,0,1,0,3'b100,32'h2A,32'h2B,32'h2C,5'd18,5'd19,5'd20), 1'b0, 1'b0);
    e = sbq.pop_front();
    n_cmp++;
    if (dut_vec() !== exp_vec(e) || bus.ValidE !== 1'b1) begin
      n_err++;
      $display("FAIL resume_after_reset got %h want %h", dut_vec(), exp_vec(e));
    end
  endtask

  task automatic test_back_to_back();
    ex_t d, e;
    logic fl;
    for (int i = 0; i < 40; i++) begin
      d = mk($urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
             $urandom_range(0,1), $urandom_range(0,1), 3'($urandom_range(0,7)),
             $urandom, $urandom, $urandom, 5'($urandom_range(0,31)),
             5'($urandom_range(0,31)), 5'($urandom_range(0,31)));
      fl = ($urandom_range(0,3) == 0);
      set_fwd(2'($urandom_range(0,3)), 2'($urandom_range(0,3)), $urandom, $urandom);
      issue(d, fl, 1'b0);
      if (sbq.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b2b[%0d] scoreboard empty", i);
      end else begin
        e = sbq.pop_front();
        n_cmp++;
        if (dut_vec() !== exp_vec(e)) begin
          n_err++;
          $display("FAIL b2b[%0d] flush=%b got %h want %h", i, fl, dut_vec(), exp_vec(e));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.FlushE = 1'b0;
    set_fwd(2'b00, 2'b00, 32'h0, 32'h0);
    test_reset();
    test_load();
    test_imm_dst();
    test_forward();
    test_flush();
    test_reset_prio();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
